dp_ram_clr: RTL and testbench

Parametrised successor to the processor's single-port RAM.
- Port A: read/write. Port B: read-only. Both ports have registered (synchronous) reads with valid strobes.
- A hardware clear engine fills the whole array with a constant after reset or on request.
- Sits between the CPU datapath (port A) and a debug/display reader (port B). It is the data memory for wider or deeper processor variants.

---
 rtl/dp_ram_clr_if.sv | 29 ++
 rtl/dp_ram_clr.sv | 138 +++++++++++++
 tb/tb_dp_ram_clr.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_ram_clr_if.sv
// dp_ram_clr bus bundle: clear control plus port A (r/w) and port B (read).
// master drives requests, slave is the RAM.
interface dp_ram_clr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  clr_req;
    logic                  busy;
    logic                  a_en;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_din;
    logic [DATA_WIDTH-1:0] a_dout;
    logic                  a_valid;
    logic                  b_en;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  b_valid;

    modport master (
        output clr_req, a_en, a_we, a_addr, a_din, b_en, b_addr,
        input  busy, a_dout, a_valid, b_dout, b_valid
    );

    modport slave (
        input  clr_req, a_en, a_we, a_addr, a_din, b_en, b_addr,
        output busy, a_dout, a_valid, b_dout, b_valid
    );
endinterface

// File: rtl/dp_ram_clr.sv
// Dual-port RAM (A r/w, B read) with registered reads and a clear engine.
// Macro RAM_WRITE_FIRST_EN: A-write/B-read collision returns new data on B.
module dp_ram_clr #(
    parameter int                      DATA_WIDTH     = 8,
    parameter int                      ADDR_WIDTH     = 8,
    parameter int                      CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE    = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    dp_ram_clr_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;
    logic                  clr_we;

    logic                  port_ok;
    logic                  a_wr;
    logic                  a_rd;
    logic                  b_rd;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] b_rdata;

    assign bus.busy = (state == CLEAR);
    assign port_ok  = (state == IDLE);
    assign a_wr     = port_ok & bus.a_en & bus.a_we;
    assign a_rd     = port_ok & bus.a_en & ~bus.a_we;
    assign b_rd     = port_ok & bus.b_en;

    // Clear engine state and word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Clear engine next state: walk every word once, then release the array.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Single write port shared by the clear engine and port A.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.a_addr;
        mem_wdata = bus.a_din;
        if (rst_n) begin
            if (clr_we) begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = CLEAR_VALUE;
            end else if (a_wr) begin
                mem_we = 1'b1;
            end
        end
    end

    // Array storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef RAM_WRITE_FIRST_EN
    assign b_rdata = (a_wr && (bus.a_addr == bus.b_addr)) ? bus.a_din
                                                          : mem[bus.b_addr];
`else
    assign b_rdata = mem[bus.b_addr];
`endif

    // Port A registered read with one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.a_dout  <= '0;
            bus.a_valid <= 1'b0;
        end else begin
            bus.a_valid <= a_rd;
            if (a_rd) begin
                bus.a_dout <= mem[bus.a_addr];
            end
        end
    end

    // Port B registered read with one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.b_dout  <= '0;
            bus.b_valid <= 1'b0;
        end else begin
            bus.b_valid <= b_rd;
            if (b_rd) begin
                bus.b_dout <= b_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dp_ram_clr.sv
// Randomised + directed bench for dp_ram_clr against a word-level model.
// dut0: defaults; dut1: CLEAR_VALUE=0x3C, CLEAR_ON_RESET=0.
module tb_dp_ram_clr;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n   = 1'b0;
    logic          clr_req = 1'b0;
    logic          a_en    = 1'b0;
    logic          a_we    = 1'b0;
    logic [AW-1:0] a_addr  = '0;
    logic [DW-1:0] a_din   = '0;
    logic          b_en    = 1'b0;
    logic [AW-1:0] b_addr  = '0;

    dp_ram_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    dp_ram_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.clr_req = clr_req;
    assign bus0.a_en    = a_en;
    assign bus0.a_we    = a_we;
    assign bus0.a_addr  = a_addr;
    assign bus0.a_din   = a_din;
    assign bus0.b_en    = b_en;
    assign bus0.b_addr  = b_addr;
    assign bus1.clr_req = clr_req;
    assign bus1.a_en    = a_en;
    assign bus1.a_we    = a_we;
    assign bus1.a_addr  = a_addr;
    assign bus1.a_din   = a_din;
    assign bus1.b_en    = b_en;
    assign bus1.b_addr  = b_addr;

    dp_ram_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    dp_ram_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h3C)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    logic [7:0] m_mem [2][DEPTH];
    bit         m_kn  [2][DEPTH];
    int         m_left [2];
    logic [7:0] m_ad [2];
    logic [7:0] m_bd [2];
    bit         m_av [2];
    bit         m_bv [2];
    bit         m_akn [2];
    bit         m_bkn [2];
    int         cor [2] = '{1, 0};
    logic [7:0] cv  [2] = '{8'h00, 8'h3C};

`ifdef RAM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Word-level reference: remaining-clear countdown plus a plain array.
    task automatic model_edge(int k);
        int idx;
        if (!rst_n) begin
            m_ad[k] = '0; m_bd[k] = '0;
            m_av[k] = 0;  m_bv[k] = 0;
            m_akn[k] = 1; m_bkn[k] = 1;
            m_left[k] = cor[k] ? DEPTH : 0;
        end else if (m_left[k] > 0) begin
            idx = DEPTH - m_left[k];
            m_mem[k][idx] = cv[k];
            m_kn[k][idx]  = 1;
            m_left[k]--;
            m_av[k] = 0;
            m_bv[k] = 0;
        end else begin
            m_av[k] = 0;
            m_bv[k] = 0;
            if (b_en) begin
                m_bv[k]  = 1;
                m_bd[k]  = m_mem[k][b_addr];
                m_bkn[k] = m_kn[k][b_addr];
                if (WF && a_en && a_we && a_addr == b_addr) begin
                    m_bd[k]  = a_din;
                    m_bkn[k] = 1;
                end
            end
            if (a_en && !a_we) begin
                m_av[k]  = 1;
                m_ad[k]  = m_mem[k][a_addr];
                m_akn[k] = m_kn[k][a_addr];
            end
            if (a_en && a_we) begin
                m_mem[k][a_addr] = a_din;
                m_kn[k][a_addr]  = 1;
            end
            if (clr_req) m_left[k] = DEPTH;
        end
    endtask

    task automatic compare(int k);
        logic          g_busy, g_av, g_bv;
        logic [7:0]    g_ad, g_bd;
        if (k == 0) begin
            g_busy = bus0.busy; g_av = bus0.a_valid; g_bv = bus0.b_valid;
            g_ad = bus0.a_dout; g_bd = bus0.b_dout;
        end else begin
            g_busy = bus1.busy; g_av = bus1.a_valid; g_bv = bus1.b_valid;
            g_ad = bus1.a_dout; g_bd = bus1.b_dout;
        end
        check($sformatf("busy%0d", k), 32'(g_busy), 32'(m_left[k] > 0));
        check($sformatf("a_valid%0d", k), 32'(g_av), 32'(m_av[k]));
        check($sformatf("b_valid%0d", k), 32'(g_bv), 32'(m_bv[k]));
        if (m_akn[k]) check($sformatf("a_dout%0d", k), 32'(g_ad), 32'(m_ad[k]));
        if (m_bkn[k]) check($sformatf("b_dout%0d", k), 32'(g_bd), 32'(m_bd[k]));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) started = 1'b1;
        if (started) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        if (started) begin
            compare(0);
            compare(1);
        end
    endtask

    task automatic idle_in();
        clr_req = 0; a_en = 0; a_we = 0; b_en = 0;
    endtask

    task automatic cyc(bit ae, bit awe, logic [7:0] aa, logic [7:0] ad,
                       bit be, logic [7:0] ba, bit cr);
        a_en = ae; a_we = awe; a_addr = aa; a_din = ad;
        b_en = be; b_addr = ba; clr_req = cr;
        step();
        idle_in();
    endtask

    task automatic rand_in();
        a_en   = 1'($urandom);
        a_we   = 1'($urandom);
        a_addr = 8'($urandom_range(0, 15));
        a_din  = 8'($urandom);
        b_en   = 1'($urandom);
        b_addr = 8'($urandom_range(0, 15));
    endtask

    // Runs while dut0 is busy with random port traffic; bounded.
    task automatic run_busy(int stop_at, int req_at, output int n);
        n = 0;
        while (bus0.busy === 1'b1 && n < 1000 && n != stop_at) begin
            rand_in();
            clr_req = (n == req_at);
            n++;
            step();
            idle_in();
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) begin
                m_kn[k][i]  = 0;
                m_mem[k][i] = '0;
            end

        // 1: reset then power-on clear
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        run_busy(-1, -1, n);
        check("p1_busy_len", n, 256);
        cyc(1, 0, 8'h00, 8'h00, 1, 8'h7F, 0);
        check("p1_a00", bus0.a_dout, 8'h00);
        check("p1_b7f", bus0.b_dout, 8'h00);
        cyc(1, 0, 8'hFF, 8'h00, 0, 8'h00, 0);
        check("p1_aff_v", bus0.a_valid, 1);

        // 2: write then read on A
        cyc(1, 1, 8'h10, 8'hA5, 0, 8'h00, 0);
        check("p2_wr_v", bus0.a_valid, 0);
        cyc(1, 0, 8'h10, 8'h00, 0, 8'h00, 0);
        check("p2_rd", bus0.a_dout, 8'hA5);
        check("p2_rd_v", bus0.a_valid, 1);
        step();
        check("p2_hold", bus0.a_dout, 8'hA5);
        check("p2_hold_v", bus0.a_valid, 0);

        // 3: clear with non-zero value, traffic ignored while busy
        cyc(1, 1, 8'h20, 8'h11, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
        check("p3_busy1", bus1.busy, 1);
        run_busy(-1, -1, n);
        check("p3_busy_len", n, 256);
        cyc(1, 0, 8'h20, 8'h00, 0, 8'h00, 0);
        check("p3_clr1", bus1.a_dout, 8'h3C);
        check("p3_clr0", bus0.a_dout, 8'h00);

        // 4: collision
        cyc(1, 1, 8'h40, 8'h55, 0, 8'h00, 0);
        cyc(1, 1, 8'h40, 8'h99, 1, 8'h40, 0);
        check("p4_coll", bus0.b_dout, WF ? 8'h99 : 8'h55);
        cyc(0, 0, 8'h00, 8'h00, 1, 8'h40, 0);
        check("p4_after", bus0.b_dout, 8'h99);

        // 5: reset mid-clear, retention without clear-on-reset
        cyc(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
        run_busy(100, -1, n);
        check("p5_mid", n, 100);
        rst_n = 0;
        step();
        rst_n = 1;
        check("p5_idle1", bus1.busy, 0);
        cyc(1, 1, 8'h05, 8'h77, 0, 8'h00, 0);
        rst_n = 0;
        step();
        rst_n = 1;
        cyc(1, 0, 8'h05, 8'h00, 0, 8'h00, 0);
        check("p5_keep", bus1.a_dout, 8'h77);
        check("p5_keep_v", bus1.a_valid, 1);
        run_busy(-1, -1, n);
        check("p5_busy_len", n + 1, 256);

        // 6: back-to-back B reads, then second clr_req during busy
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 8'(i), 8'(i + 1), 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'h00, 8'h00, 1, 8'(i), 0);
            check("p6_bv", bus0.b_valid, 1);
            check("p6_bd", bus0.b_dout, 32'(i + 1));
        end
        cyc(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
        run_busy(-1, 50, n);
        check("p6_busy_len", n, 256);

        // random traffic with rare clears and resets
        for (int c = 0; c < 4000; c++) begin
            rand_in();
            if ($urandom_range(0, 3) == 0) a_addr = 8'($urandom);
            clr_req = ($urandom_range(0, 299) == 0);
            rst_n   = ($urandom_range(0, 799) != 0);
            step();
            idle_in();
            rst_n = 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
